pipe_mem_stage: RTL and testbench
=================================

// Module: pipe_mem_stage
// PURPOSE
//   MEM stage of the 5-stage pipelined CPU. Sits between the EX/MEM pipeline
//   register and the MEM/WB pipeline register. Holds the word-addressed data
//   RAM and the memory-mapped I/O block (output port registers, synchronised
//   input ports, free-running cycle counter). Produces mmo, the load data that
//   MEM/WB latches on the same rising edge.
// PARAMETERS
//   AW        5    data RAM word-address width; depth = 2**AW words (32)
//   IN_W      32   width of each input port; zero-extended to 32 bits on read
// PORTS
//   clock     in   1     system clock; all state updates on rising edge
//   resetn    in   1     synchronous active-low reset
//   mwmem     in   1     store enable from EX/MEM (sw in MEM stage)
//   malu      in   32    byte address from ALU result
//   mb        in   32    store data (rt value after forwarding)
//   in_port0  in   IN_W  external input (switches), asynchronous to clock
//   in_port1  in   IN_W  external input (switches), asynchronous to clock
//   mmo       out  32    load data, combinational from malu, valid same cycle
//   out_port0 out  32    output register (LED / 7-seg)
//   out_port1 out  32    output register
//   out_port2 out  32    output register
// BEHAVIOUR
//   Address decode (malu[1:0] ignored, no misalignment trap):
//     malu[7]==0          -> RAM word malu[AW+1:2]; malu[31:AW+2] ignored (aliases)
//     0x80/0x84/0x88      -> out_port0/1/2 (read-back returns register value)
//     0xC0/0xC4           -> in_port0/1 synchronised value (read-only)
//     0xC8                -> cycle counter (read-only)
//     other malu[7]==1    -> reads 0, writes dropped
//     Decode uses malu[7:0] only for I/O; malu[31:8] ignored.
//   Reads: purely combinational; mmo depends only on malu and current state.
//     No read enable; mmo valid whenever malu is.
//   Writes: on rising edge when resetn==1 and mwmem==1, to the decoded target.
//     RAM write and I/O write are mutually exclusive (malu[7]).
//     A write to an I/O address never modifies RAM.
//     Writes to read-only or unmapped addresses are ignored.
//   Read-during-write, same address, same cycle: mmo returns the OLD value.
//     New value is visible from the next cycle.
//   Input sync: each in_port passes through two flops; the value is readable
//     exactly 2 rising edges after it is stable at the pin.
//   Cycle counter: 32-bit; +1 every rising edge with resetn==1.
//     Wraps 0xFFFFFFFF -> 0.
//   Reset (resetn==0 at a rising edge):
//     out_port0..2 = 0; both sync stages = 0; counter = 0.
//     mwmem is ignored: no RAM or port write occurs.
//     RAM contents are not reset; they are preserved across reset (power-up
//       contents undefined in hardware, zero in simulation).
//     Reset asserted mid-program has the same effect; no partial write.
//   No stall or handshake: one access per cycle, zero-wait, fixed latency.
//     Load result is latched by MEM/WB at the edge ending the MEM cycle.
// TESTING
//   1 Reset: resetn=0 for 2 edges with mwmem=1, malu=0x80, mb=0xFFFF ->
//     out_port0=0; then resetn=1, malu=0xC8 -> mmo=0,1,2 on successive cycles.
//   2 RAM: store mb=0x12345678 @0x10; same cycle mmo=old value;
//     next cycle, load @0x10 -> 0x12345678; load @0x90 -> not RAM (reads 0).
//   3 Output port: store 0xA5 @0x84 -> out_port1=0xA5 after the edge;
//     out_port0/2 unchanged; load @0x04 unchanged; load @0x84 -> 0xA5.
//   4 Input sync: in_port0 0->0x3 just after edge N; load @0xC0 ->
//     mmo=0 at cycle N+1, 0x3 from cycle N+2 onward.
//   5 Aliasing/bounds: store 0xDEAD @0x7C and 0xBEEF @0x00 ->
//     load @0x7C=0xDEAD, @0x100=0xBEEF, @0x7E=0xDEAD.
//     Store to 0xC0 -> mmo @0xC0 still in_port0.
//   6 Reset mid-run: RAM @0x10=0x55, out_port2=0x77, assert resetn=0 one edge
//     -> out_port2=0, counter=0, RAM @0x10 still 0x55.

Source files
------------

// File: rtl/pipe_mem_stage_if.sv
// pipe_mem_stage_if
//   Memory-access bus between the EX/MEM pipeline register and the MEM stage.
//   Ports (signals):
//     mwmem  store enable
//     malu   byte address (ALU result)
//     mb     store data
//     mmo    load data, combinational from malu
//   master: EX/MEM side (drives mwmem/malu/mb, receives mmo)
//   slave : MEM stage (receives mwmem/malu/mb, drives mmo)
interface pipe_mem_stage_if;
  logic        mwmem;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [31:0] mmo;

  modport master (output mwmem, output malu, output mb, input mmo);
  modport slave  (input mwmem, input malu, input mb, output mmo);
endinterface

// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage
//   MEM stage of the 5-stage pipeline: word-addressed data RAM plus a small
//   memory-mapped I/O block (three output registers, two synchronised input
//   ports, a free-running cycle counter). Loads are combinational so MEM/WB
//   latches mmo at the edge that ends the MEM cycle.
//   Ports:
//     clock               system clock, rising edge
//     resetn              synchronous active-low reset (RAM is not cleared)
//     bus                 slave side of pipe_mem_stage_if (mwmem/malu/mb/mmo)
//     in_port0/in_port1   asynchronous external inputs, IN_W bits each
//     out_port0..2        output registers
//   I/O map (malu[7]==1, malu[1:0] and malu[31:8] ignored):
//     0x80/0x84/0x88 out_port0..2 (r/w), 0xC0/0xC4 in_port0/1 (r),
//     0xC8 cycle counter (r), anything else reads 0 and drops writes.
module pipe_mem_stage #(
  parameter int AW   = 5,
  parameter int IN_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  pipe_mem_stage_if.slave   bus,
  input  logic [IN_W-1:0]   in_port0,
  input  logic [IN_W-1:0]   in_port1,
  output logic [31:0]       out_port0,
  output logic [31:0]       out_port1,
  output logic [31:0]       out_port2
);

  // I/O word addresses, i.e. malu[7:2]
  localparam logic [5:0] A_OUT0 = 6'h20;  // 0x80
  localparam logic [5:0] A_OUT1 = 6'h21;  // 0x84
  localparam logic [5:0] A_OUT2 = 6'h22;  // 0x88
  localparam logic [5:0] A_IN0  = 6'h30;  // 0xC0
  localparam logic [5:0] A_IN1  = 6'h31;  // 0xC4
  localparam logic [5:0] A_CNT  = 6'h32;  // 0xC8

  logic [31:0]     ram [0:(2**AW)-1];
  logic [IN_W-1:0] sync0_a, sync0_b;
  logic [IN_W-1:0] sync1_a, sync1_b;
  logic [31:0]     cycle_cnt;

  logic            is_io;
  logic [5:0]      io_word;
  logic [AW-1:0]   ram_idx;
  logic            unused_addr;

  assign is_io       = bus.malu[7];
  assign io_word     = bus.malu[7:2];
  assign ram_idx     = bus.malu[AW+1:2];
  assign unused_addr = ^{bus.malu[31:8], bus.malu[1:0]};

  // RAM has no reset; a write is suppressed while resetn is low.
  always_ff @(posedge clock) begin
    if (resetn && bus.mwmem && !is_io)
      ram[ram_idx] <= bus.mb;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
      sync0_a   <= '0;
      sync0_b   <= '0;
      sync1_a   <= '0;
      sync1_b   <= '0;
      cycle_cnt <= '0;
    end else begin
      sync0_a   <= in_port0;
      sync0_b   <= sync0_a;
      sync1_a   <= in_port1;
      sync1_b   <= sync1_a;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (bus.mwmem && is_io) begin
        case (io_word)
          A_OUT0:  out_port0 <= bus.mb;
          A_OUT1:  out_port1 <= bus.mb;
          A_OUT2:  out_port2 <= bus.mb;
          default: ;  // read-only or unmapped: dropped
        endcase
      end
    end
  end

  // Combinational read; a same-cycle write is not bypassed, so the old value
  // is returned and the new one appears after the edge.
  always_comb begin
    bus.mmo = '0;
    if (!is_io) begin
      bus.mmo = ram[ram_idx];
    end else begin
      case (io_word)
        A_OUT0:  bus.mmo = out_port0;
        A_OUT1:  bus.mmo = out_port1;
        A_OUT2:  bus.mmo = out_port2;
        A_IN0:   bus.mmo = 32'(sync0_b);
        A_IN1:   bus.mmo = 32'(sync1_b);
        A_CNT:   bus.mmo = cycle_cnt;
        default: bus.mmo = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
module tb_pipe_mem_stage;
  logic        clock;
  logic        resetn;
  logic [31:0] in_port0, in_port1;
  logic [31:0] out_port0, out_port1, out_port2;

  pipe_mem_stage_if bus ();

  pipe_mem_stage #(.AW(5), .IN_W(32)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .out_port2 (out_port2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  logic [31:0] m_ram [32];
  logic [31:0] m_out [3];
  logic [31:0] m_cnt;
  logic [31:0] hist0 [$];
  logic [31:0] hist1 [$];

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [7:0] lo;
    lo = a[7:0] & 8'hFC;
    if (!a[7]) return m_ram[(a >> 2) % 32];
    case (lo)
      8'h80: return m_out[0];
      8'h84: return m_out[1];
      8'h88: return m_out[2];
      8'hC0: return (hist0.size() >= 2) ? hist0[hist0.size()-2] : 32'h0;
      8'hC4: return (hist1.size() >= 2) ? hist1[hist1.size()-2] : 32'h0;
      8'hC8: return m_cnt;
      default: return 32'h0;
    endcase
  endfunction

  // one rising edge; the model applies the rules to the inputs sampled there
  task automatic tick();
    logic [7:0] lo;
    @(posedge clock);
    if (!resetn) begin
      for (int i = 0; i < 3; i++) m_out[i] = 32'h0;
      m_cnt = 32'h0;
      hist0.delete();
      hist1.delete();
    end else begin
      m_cnt = m_cnt + 32'd1;
      hist0.push_back(in_port0);
      hist1.push_back(in_port1);
      if (hist0.size() > 4) void'(hist0.pop_front());
      if (hist1.size() > 4) void'(hist1.pop_front());
      if (bus.mwmem) begin
        lo = bus.malu[7:0] & 8'hFC;
        if (!bus.malu[7]) m_ram[(bus.malu >> 2) % 32] = bus.mb;
        else if (lo == 8'h80) m_out[0] = bus.mb;
        else if (lo == 8'h84) m_out[1] = bus.mb;
        else if (lo == 8'h88) m_out[2] = bus.mb;
      end
    end
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.mwmem = we;
    bus.malu  = a;
    bus.mb    = d;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b1, 32'h80, 32'hFFFF);
    tick();
    tick();
    n_vec++;
    if (out_port0 !== 32'h0) begin
      $display("FAIL reset_out_port0: got %h want %h", out_port0, 32'h0);
      n_err++;
    end
    resetn = 1'b1;
    drive(1'b0, 32'hC8, 32'h0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (bus.mmo !== 32'(k)) begin
        $display("FAIL reset_counter[%0d]: got %h want %h", k, bus.mmo, 32'(k));
        n_err++;
      end
      tick();
    end
  endtask

  task automatic fill_ram();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 32'(i * 4), $urandom);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_ram();
    drive(1'b1, 32'h10, 32'h1111_1111);
    tick();
    drive(1'b1, 32'h10, 32'h1234_5678);
    n_vec++;
    if (bus.mmo !== 32'h1111_1111) begin
      $display("FAIL ram_old_value: got %h want %h", bus.mmo, 32'h1111_1111);
      n_err++;
    end
    tick();
    drive(1'b0, 32'h10, 32'h0);
    n_vec++;
    if (bus.mmo !== 32'h1234_5678) begin
      $display("FAIL ram_new_value: got %h want %h", bus.mmo, 32'h1234_5678);
      n_err++;
    end
    drive(1'b0, 32'h90, 32'h0);
    n_vec++;
    if (bus.mmo !== 32'h0) begin
      $display("FAIL ram_unmapped_90: got %h want %h", bus.mmo, 32'h0);
      n_err++;
    end
  endtask

  task automatic test_out_port();
    logic [31:0] o0, o2, r4;
    o0 = m_out[0];
    o2 = m_out[2];
    r4 = m_ram[1];
    drive(1'b1, 32'h84, 32'hA5);
    tick();
    drive(1'b0, 32'h04, 32'h0);
    n_vec++;
    if (out_port1 !== 32'hA5 || out_port0 !== o0 || out_port2 !== o2) begin
      $display("FAIL out_ports: got %h/%h/%h want %h/%h/%h",
               out_port0, out_port1, out_port2, o0, 32'hA5, o2);
      n_err++;
    end
    n_vec++;
    if (bus.mmo !== r4) begin
      $display("FAIL out_ram_untouched: got %h want %h", bus.mmo, r4);
      n_err++;
    end
    drive(1'b0, 32'h84, 32'h0);
    n_vec++;
    if (bus.mmo !== 32'hA5) begin
      $display("FAIL out_readback: got %h want %h", bus.mmo, 32'hA5);
      n_err++;
    end
  endtask

  task automatic test_in_sync();
    logic [31:0] want [3];
    want[0] = 32'h0; want[1] = 32'h0; want[2] = 32'h3;
    in_port0 = 32'h0;
    drive(1'b0, 32'hC0, 32'h0);
    tick();
    tick();
    in_port0 = 32'h3;  // changes just after edge N
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (bus.mmo !== want[k] || bus.mmo !== exp_read(32'hC0)) begin
        $display("FAIL in_sync[N+%0d]: got %h want %h", k, bus.mmo, want[k]);
        n_err++;
      end
      tick();
    end
    n_vec++;
    if (bus.mmo !== 32'h3) begin
      $display("FAIL in_sync_hold: got %h want %h", bus.mmo, 32'h3);
      n_err++;
    end
  endtask

  task automatic test_alias();
    drive(1'b1, 32'h7C, 32'hDEAD);
    tick();
    drive(1'b1, 32'h00, 32'hBEEF);
    tick();
    drive(1'b0, 32'h7C, 32'h0);
    n_vec++;
    if (bus.mmo !== 32'hDEAD) begin
      $display("FAIL alias_7c: got %h want %h", bus.mmo, 32'hDEAD);
      n_err++;
    end
    drive(1'b0, 32'h100, 32'h0);
    n_vec++;
    if (bus.mmo !== 32'hBEEF) begin
      $display("FAIL alias_100: got %h want %h", bus.mmo, 32'hBEEF);
      n_err++;
    end
    drive(1'b0, 32'h7E, 32'h0);
    n_vec++;
    if (bus.mmo !== 32'hDEAD) begin
      $display("FAIL alias_7e: got %h want %h", bus.mmo, 32'hDEAD);
      n_err++;
    end
    drive(1'b1, 32'hC0, 32'hFFFF_0000);
    tick();
    drive(1'b0, 32'hC0, 32'h0);
    n_vec++;
    if (bus.mmo !== in_port0) begin
      $display("FAIL ro_in_port0: got %h want %h", bus.mmo, in_port0);
      n_err++;
    end
    drive(1'b0, 32'h00, 32'h0);
    n_vec++;
    if (bus.mmo !== 32'hBEEF) begin
      $display("FAIL ro_write_no_ram: got %h want %h", bus.mmo, 32'hBEEF);
      n_err++;
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h10, 32'h55);
    tick();
    drive(1'b1, 32'h88, 32'h77);
    tick();
    resetn = 1'b0;
    drive(1'b1, 32'h10, 32'h99);
    tick();
    resetn = 1'b1;
    drive(1'b0, 32'hC8, 32'h0);
    n_vec++;
    if (out_port2 !== 32'h0) begin
      $display("FAIL midreset_out2: got %h want %h", out_port2, 32'h0);
      n_err++;
    end
    n_vec++;
    if (bus.mmo !== 32'h0) begin
      $display("FAIL midreset_counter: got %h want %h", bus.mmo, 32'h0);
      n_err++;
    end
    drive(1'b0, 32'h10, 32'h0);
    n_vec++;
    if (bus.mmo !== 32'h55) begin
      $display("FAIL midreset_ram: got %h want %h", bus.mmo, 32'h55);
      n_err++;
    end
  endtask

  task automatic test_random();
    logic [7:0]  codes [10];
    logic [31:0] a, e;
    codes = '{8'h80, 8'h84, 8'h88, 8'hC0, 8'hC4, 8'hC8, 8'h8C, 8'hA0, 8'hCC, 8'hFC};
    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      if ($urandom_range(1)) a = {a[31:8], codes[$urandom_range(9)] | {6'h0, a[1:0]}};
      resetn   = ($urandom_range(19) != 0);
      in_port0 = $urandom;
      in_port1 = $urandom;
      drive($urandom_range(1) == 1, a, $urandom);
      e = exp_read(a);
      n_vec++;
      if (bus.mmo !== e) begin
        $display("FAIL rand_mmo[%0d] addr %h: got %h want %h", n, a, bus.mmo, e);
        n_err++;
      end
      n_vec++;
      if (out_port0 !== m_out[0] || out_port1 !== m_out[1] || out_port2 !== m_out[2]) begin
        $display("FAIL rand_outs[%0d]: got %h/%h/%h want %h/%h/%h", n,
                 out_port0, out_port1, out_port2, m_out[0], m_out[1], m_out[2]);
        n_err++;
      end
      tick();
    end
    resetn = 1'b1;
  endtask

  initial begin
    resetn   = 1'b0;
    in_port0 = 32'h0;
    in_port1 = 32'h0;
    for (int i = 0; i < 32; i++) m_ram[i] = 32'h0;
    for (int i = 0; i < 3; i++) m_out[i] = 32'h0;
    m_cnt = 32'h0;
    drive(1'b0, 32'h0, 32'h0);
    test_reset();
    fill_ram();
    test_ram();
    test_out_port();
    test_in_sync();
    test_alias();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
